// File: rtl/wpn_melee_hit_detect.sv
// Melee weapon hit detection.
// Rebuilds the weapon hitbox from the sprite drive signals and tests it
// against one enemy box. A two-stage pipeline (edges, then overlap) feeds
// a per-swing FSM that issues at most one damage event per swing and keeps
// the enemy HP, death flag and invulnerability window.
module wpn_melee_hit_detect #(
  parameter int WPN_W         = 40,
  parameter int WPN_H         = 12,
  parameter int ENEMY_W       = 64,
  parameter int ENEMY_H       = 64,
  parameter int ENEMY_HP_INIT = 100,
  parameter int DAMAGE        = 10,
  parameter int IFRAMES       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        attack_active,
  input  logic [11:0] pos_x_wpn_offset,
  input  logic [11:0] pos_y_wpn_offset,
  input  logic [11:0] anim_x_offset,
  input  logic        flip_hor_melee,
  input  logic [11:0] enemy_x,
  input  logic [11:0] enemy_y,
  input  logic        enemy_respawn,
  output logic        hit_pulse,
  output logic [7:0]  enemy_hp,
  output logic        enemy_dead,
  output logic        invuln
);

  // Counter wide enough to hold IFRAMES; at least one bit when IFRAMES is 0.
  localparam int CNT_W = (IFRAMES < 1) ? 1 : $clog2(IFRAMES + 1);

  localparam logic signed [13:0] WPN_W_S   = 14'(WPN_W);
  localparam logic signed [13:0] WPN_H_S   = 14'(WPN_H);
  localparam logic signed [13:0] ENEMY_W_S = 14'(ENEMY_W);
  localparam logic signed [13:0] ENEMY_H_S = 14'(ENEMY_H);
  localparam logic signed [13:0] ONE_S     = 14'sd1;
  localparam logic [7:0]         HP_INIT_C = 8'(ENEMY_HP_INIT);
  localparam logic [7:0]         DMG_C     = 8'(DAMAGE);
  localparam logic [CNT_W-1:0]   IFR_C     = CNT_W'(IFRAMES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;
  localparam logic [1:0] S_SPENT = 2'd3;

  // HP after one hit, floored at zero.
  function automatic logic [7:0] sub_damage(input logic [7:0] hp);
    return (hp <= DMG_C) ? 8'd0 : (hp - DMG_C);
  endfunction

  // Positions are unsigned pixels, the swing offset is signed; all edges
  // are carried as 14-bit signed so boxes may hang off either screen side.
  logic signed [13:0] px_s, py_s, ax_s, ex_s, ey_s;
  assign px_s = $signed({2'b00, pos_x_wpn_offset});
  assign py_s = $signed({2'b00, pos_y_wpn_offset});
  assign ax_s = $signed({{2{anim_x_offset[11]}}, anim_x_offset});
  assign ex_s = $signed({2'b00, enemy_x});
  assign ey_s = $signed({2'b00, enemy_y});

  logic signed [13:0] wl_p1_d, wr_p1_d, wt_p1_d, wb_p1_d;
  logic signed [13:0] el_p1_d, er_p1_d, et_p1_d, eb_p1_d;
  logic signed [13:0] wl_p1_q, wr_p1_q, wt_p1_q, wb_p1_q;
  logic signed [13:0] el_p1_q, er_p1_q, et_p1_q, eb_p1_q;
  logic               tick_p1_d, tick_p1_q;
  logic               overlap_p2_d, overlap_p2_q;
  logic               tick_p2_d, tick_p2_q;

  logic [1:0]       state_d, state_q;
  logic [7:0]       hp_d, hp_q;
  logic             dead_d, dead_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Stage 1 inputs: weapon edges mirror around the anchor when flipped.
  always_comb begin
    if (flip_hor_melee) begin
      wr_p1_d = px_s - ax_s;
      wl_p1_d = wr_p1_d - WPN_W_S + ONE_S;
    end else begin
      wl_p1_d = px_s + ax_s;
      wr_p1_d = wl_p1_d + WPN_W_S - ONE_S;
    end
    wt_p1_d   = py_s;
    wb_p1_d   = py_s + WPN_H_S - ONE_S;
    el_p1_d   = ex_s;
    er_p1_d   = ex_s + ENEMY_W_S - ONE_S;
    et_p1_d   = ey_s;
    eb_p1_d   = ey_s + ENEMY_H_S - ONE_S;
    tick_p1_d = frame_tick;
  end

  // Stage 2 inputs: inclusive signed box overlap, tick follows alongside.
  always_comb begin
    overlap_p2_d = (wl_p1_q <= er_p1_q) && (wr_p1_q >= el_p1_q) &&
                   (wt_p1_q <= eb_p1_q) && (wb_p1_q >= et_p1_q);
    tick_p2_d    = tick_p1_q;
  end

  // Stage 1 / stage 2 pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wl_p1_q      <= '0;
      wr_p1_q      <= '0;
      wt_p1_q      <= '0;
      wb_p1_q      <= '0;
      el_p1_q      <= '0;
      er_p1_q      <= '0;
      et_p1_q      <= '0;
      eb_p1_q      <= '0;
      tick_p1_q    <= 1'b0;
      overlap_p2_q <= 1'b0;
      tick_p2_q    <= 1'b0;
    end else begin
      wl_p1_q      <= wl_p1_d;
      wr_p1_q      <= wr_p1_d;
      wt_p1_q      <= wt_p1_d;
      wb_p1_q      <= wb_p1_d;
      el_p1_q      <= el_p1_d;
      er_p1_q      <= er_p1_d;
      et_p1_q      <= et_p1_d;
      eb_p1_q      <= eb_p1_d;
      tick_p1_q    <= tick_p1_d;
      overlap_p2_q <= overlap_p2_d;
      tick_p2_q    <= tick_p2_d;
    end
  end

  assign invuln    = (cnt_q != '0);
  assign hit_pulse = (state_q == S_HIT);

  // Swing FSM: one decision per frame tick, one hit per swing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (attack_active) state_d = S_ARMED;
      S_ARMED: begin
        if (!attack_active)
          state_d = S_IDLE;
        else if (tick_p2_q && overlap_p2_q && !invuln && !dead_q)
          state_d = S_HIT;
      end
      S_HIT:   state_d = S_SPENT;
      S_SPENT: if (!attack_active) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // HP, iframe counter and death flag; respawn overrides a same-cycle hit.
  always_comb begin
    hp_d  = hp_q;
    cnt_d = cnt_q;
    if (tick_p2_q && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
    if (state_q == S_HIT) begin
      hp_d  = sub_damage(hp_q);
      cnt_d = IFR_C;
    end
    if (enemy_respawn) begin
      hp_d  = HP_INIT_C;
      cnt_d = '0;
    end
    dead_d = (hp_q == 8'd0);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hp_q    <= HP_INIT_C;
      dead_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      dead_q  <= dead_d;
      cnt_q   <= cnt_d;
    end
  end

  assign enemy_hp   = hp_q;
  assign enemy_dead = dead_q;

endmodule

// File: tb/tb_wpn_melee_hit_detect.sv
// Bench for wpn_melee_hit_detect. Two instances share the stimulus:
// u_a uses the default parameters, u_b has no invulnerability window and
// a low starting HP so that the death path is reachable in a few swings.
module tb_wpn_melee_hit_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        attack_active;
  logic [11:0] pos_x, pos_y, anim, ex, ey;
  logic        flip;
  logic        enemy_respawn;

  logic       hit_a, dead_a, inv_a;
  logic [7:0] hp_a;
  logic       hit_b, dead_b, inv_b;
  logic [7:0] hp_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wpn_melee_hit_detect u_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .attack_active(attack_active),
    .pos_x_wpn_offset(pos_x), .pos_y_wpn_offset(pos_y), .anim_x_offset(anim),
    .flip_hor_melee(flip), .enemy_x(ex), .enemy_y(ey), .enemy_respawn(enemy_respawn),
    .hit_pulse(hit_a), .enemy_hp(hp_a), .enemy_dead(dead_a), .invuln(inv_a)
  );

  wpn_melee_hit_detect #(.ENEMY_HP_INIT(25), .IFRAMES(0)) u_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .attack_active(attack_active),
    .pos_x_wpn_offset(pos_x), .pos_y_wpn_offset(pos_y), .anim_x_offset(anim),
    .flip_hor_melee(flip), .enemy_x(ex), .enemy_y(ey), .enemy_respawn(enemy_respawn),
    .hit_pulse(hit_b), .enemy_hp(hp_b), .enemy_dead(dead_b), .invuln(inv_b)
  );

  typedef struct {
    logic        flip;
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] an;
    logic [11:0] ex;
    logic [11:0] ey;
    int          hit;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and stop 1 time unit after the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_geo(input logic f, input logic [11:0] px, input logic [11:0] py,
                         input logic [11:0] an, input logic [11:0] x, input logic [11:0] y);
    flip = f; pos_x = px; pos_y = py; anim = an; ex = x; ey = y;
  endtask

  task automatic respawn();
    enemy_respawn = 1'b1;
    clk_n(1);
    enemy_respawn = 1'b0;
  endtask

  // One frame tick, then six edges of observation. lat_a is the edge
  // index (1 = the edge that samples the tick) of u_a's first pulse.
  task automatic fire_tick(output int lat_a, output int n_a, output int n_b);
    lat_a = 0; n_a = 0; n_b = 0;
    frame_tick = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      clk_n(1);
      frame_tick = 1'b0;
      if (hit_a) begin
        n_a++;
        if (lat_a == 0) lat_a = n;
      end
      if (hit_b) n_b++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int lat, na, nb, sum;

    // flip, pos_x, pos_y, anim, enemy_x, enemy_y, expected hits
    vt[0]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd150, 12'd190, 1};
    vt[1]  = '{1'b1, 12'd100, 12'd200, 12'd20,  12'd10,  12'd190, 1};
    vt[2]  = '{1'b1, 12'd100, 12'd200, 12'd20,  12'd0,   12'd190, 1};
    vt[3]  = '{1'b1, 12'd100, 12'd200, 12'd20,  12'd200, 12'd190, 0};
    vt[4]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd159, 12'd190, 1};
    vt[5]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd160, 12'd190, 0};
    vt[6]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd57,  12'd190, 1};
    vt[7]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd56,  12'd190, 0};
    vt[8]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd150, 12'd211, 1};
    vt[9]  = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd150, 12'd212, 0};
    vt[10] = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd150, 12'd137, 1};
    vt[11] = '{1'b0, 12'd100, 12'd200, 12'd20,  12'd150, 12'd136, 0};
    vt[12] = '{1'b0, 12'd100, 12'd200, 12'hF88, 12'd0,   12'd190, 1};
    vt[13] = '{1'b0, 12'd100, 12'd200, 12'hF88, 12'd20,  12'd190, 0};
    vt[14] = '{1'b1, 12'd10,  12'd200, 12'd20,  12'd0,   12'd190, 0};
    vt[15] = '{1'b1, 12'd100, 12'd200, 12'd20,  12'd81,  12'd190, 0};
    vt[16] = '{1'b1, 12'd100, 12'd200, 12'd20,  12'd80,  12'd190, 1};

    rst = 1'b0; frame_tick = 1'b0; attack_active = 1'b0; enemy_respawn = 1'b0;
    set_geo(1'b0, 12'd0, 12'd0, 12'd0, 12'd2000, 12'd2000);
    clk_n(2);
    check("reset_hp_a", hp_a, 100);
    check("reset_hit_a", hit_a, 0);
    check("reset_inv_a", inv_a, 0);
    check("reset_dead_a", dead_a, 0);
    check("reset_hp_b", hp_b, 25);
    rst = 1'b1;
    clk_n(1);

    // Facing right: pulse latency, damage and invulnerability.
    set_geo(1'b0, 12'd100, 12'd200, 12'd20, 12'd150, 12'd190);
    attack_active = 1'b1;
    clk_n(3);
    fire_tick(lat, na, nb);
    check("right_latency", lat, 3);
    check("right_hits_a", na, 1);
    check("right_hp_a", hp_a, 90);
    check("right_inv_a", inv_a, 1);
    check("right_hp_b", hp_b, 15);
    check("noiframe_inv_b", inv_b, 0);

    // Asynchronous reset in the middle of a spent swing.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_hp_a", hp_a, 100);
    check("async_inv_a", inv_a, 0);
    check("async_hit_a", hit_a, 0);
    check("async_hp_b", hp_b, 25);
    @(posedge clk);
    #1 rst = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("after_reset_hits_a", na, 1);
    check("after_reset_hp_a", hp_a, 90);
    attack_active = 1'b0;
    clk_n(2);

    // Geometry table on u_b, fresh HP for each vector.
    for (int i = 0; i < 17; i++) begin
      respawn();
      set_geo(vt[i].flip, vt[i].px, vt[i].py, vt[i].an, vt[i].ex, vt[i].ey);
      attack_active = 1'b1;
      clk_n(3);
      fire_tick(lat, na, nb);
      check($sformatf("vec%0d_hits", i), nb, vt[i].hit);
      check($sformatf("vec%0d_hp", i), hp_b, (vt[i].hit != 0) ? 15 : 25);
      attack_active = 1'b0;
      clk_n(2);
    end

    // One hit per swing with the overlap held for 30 ticks.
    respawn();
    set_geo(1'b0, 12'd100, 12'd200, 12'd20, 12'd150, 12'd190);
    attack_active = 1'b1;
    clk_n(3);
    sum = 0;
    repeat (30) begin
      fire_tick(lat, na, nb);
      sum += nb;
    end
    check("held_swing_hits_b", sum, 1);
    check("held_swing_hp_b", hp_b, 15);
    attack_active = 1'b0;
    clk_n(2);
    attack_active = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("second_swing_hits_b", nb, 1);
    check("second_swing_hp_b", hp_b, 5);
    attack_active = 1'b0;
    clk_n(2);

    // Killing blow: HP floors at 0, dead follows one clock later.
    attack_active = 1'b1;
    clk_n(2);
    frame_tick = 1'b1;
    clk_n(1);
    frame_tick = 1'b0;
    clk_n(2);
    check("kill_pulse_b", hit_b, 1);
    clk_n(1);
    check("kill_hp_b", hp_b, 0);
    check("kill_dead_early_b", dead_b, 0);
    clk_n(1);
    check("kill_dead_b", dead_b, 1);
    attack_active = 1'b0;
    clk_n(2);
    attack_active = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("dead_swing_hits_b", nb, 0);
    check("dead_swing_hp_b", hp_b, 0);
    attack_active = 1'b0;
    clk_n(2);
    respawn();
    check("respawn_hp_b", hp_b, 25);
    check("respawn_dead_lag_b", dead_b, 1);
    clk_n(1);
    check("respawn_dead_b", dead_b, 0);

    // Invulnerability window on u_a: 20 ticks after a hit.
    respawn();
    attack_active = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("inv_first_hits_a", na, 1);
    check("inv_first_hp_a", hp_a, 90);
    attack_active = 1'b0;
    clk_n(1);
    repeat (4) fire_tick(lat, na, nb);
    attack_active = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("inv_blocked_hits_a", na, 0);
    check("inv_blocked_hp_a", hp_a, 90);
    check("inv_blocked_inv_a", inv_a, 1);
    attack_active = 1'b0;
    clk_n(1);
    repeat (14) fire_tick(lat, na, nb);
    check("inv_tick19_a", inv_a, 1);
    fire_tick(lat, na, nb);
    check("inv_tick20_a", inv_a, 0);
    attack_active = 1'b1;
    clk_n(2);
    fire_tick(lat, na, nb);
    check("inv_expired_hits_a", na, 1);
    check("inv_expired_hp_a", hp_a, 80);
    attack_active = 1'b0;
    clk_n(1);

    // Respawn landing in the HIT cycle: reload wins, pulse still fires.
    respawn();
    attack_active = 1'b1;
    clk_n(2);
    frame_tick = 1'b1;
    clk_n(1);
    frame_tick = 1'b0;
    clk_n(2);
    check("coinc_pulse_a", hit_a, 1);
    enemy_respawn = 1'b1;
    clk_n(1);
    enemy_respawn = 1'b0;
    check("coinc_hp_a", hp_a, 100);
    check("coinc_inv_a", inv_a, 0);
    check("coinc_pulse_end_a", hit_a, 0);
    attack_active = 1'b0;
    clk_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
